input_port_ydma: RTL and testbench
==================================

// Module: input_port_ydma
// PURPOSE
//  Receive-side counterpart of the ydma output port. Accepts BFT packets addressed to this port.
//  Writes each payload into a local buffer at the packet's fifo_addr and streams entries to the user in address order.
//  Returns freespace credits to the sender every FREESPACE_UPDATE_SIZE consumed words, closing the credit loop.
// PARAMETERS
//  PACKET_BITS           97  total packet width, bit PACKET_BITS-1 = packet valid
//  NUM_LEAF_BITS         6   leaf id field width
//  NUM_PORT_BITS         4   port id field width
//  NUM_ADDR_BITS         7   fifo_addr field width; buffer depth = 2**NUM_ADDR_BITS
//  PAYLOAD_BITS          64  payload width
//  FREESPACE_UPDATE_SIZE 64  words consumed per credit packet (< 2**NUM_ADDR_BITS)
//  PORT_ID               2   this block's dst_port value
//  CREDIT_CNT_BITS       4   width of pending-credit counter
// PORTS
//  clk                      in   1            single clock
//  reset                    in   1            asynchronous, active-high
//  internal_in              in   PACKET_BITS  {vld, dst_leaf, dst_port, rsvd, fifo_addr, payload}
//  ret_leaf                 in   NUM_LEAF_BITS  sender leaf for credit packets
//  ret_port                 in   NUM_PORT_BITS  sender port for credit packets
//  update_ret_en            in   1            latch ret_leaf/ret_port
//  dout_leaf_interface2user out  PAYLOAD_BITS user data
//  vld_interface2user       out  1            user data valid
//  ack_user2interface       in   1            user accepts data this cycle
//  credit_packet            out  PACKET_BITS  credit packet toward network
//  credit_vld               out  1            credit_packet valid
//  credit_ack               in   1            network took credit_packet
//  ap_start                 in   1            enable streaming to user
// BEHAVIOUR
//  - Reset (async): valid bitmap = 0, rd_ptr = 0, out reg empty, consumed cnt = 0, pending = 0.
//    ret regs = 0; all outputs 0.
//  - Accept: internal_in[MSB]==1 && dst_port==PORT_ID. Then on the edge: mem[fifo_addr] <= payload, bitmap[fifo_addr] <= 1.
//  - Out stage: one register. Load when bitmap[rd_ptr] && ap_start && (out empty || ack_user2interface).
//    Load sets dout <= mem[rd_ptr], clears bitmap[rd_ptr], rd_ptr <= rd_ptr+1 mod 2**NUM_ADDR_BITS.
//  - Latency: packet on cycle N -> vld_interface2user high at cycle N+2 when buffer was empty.
//    Back-to-back ack sustains 1 word/cycle.
//  - Handshake: data consumed on vld && ack. vld/dout stable while vld && !ack.
//    ack with vld low is ignored.
//  - Same-cycle write to rd_ptr entry and read: read sees old bitmap; data delivered next cycle.
//  - rd_ptr stalls on a hole (out-of-order arrival). It resumes when the missing address is written.
//  - Credits: consumed cnt increments per handshake. On reaching FREESPACE_UPDATE_SIZE it resets to 0 and pending++.
//    pending decrements on credit_vld && credit_ack.
//    Simultaneous ++/-- holds pending. pending saturates at 2**CREDIT_CNT_BITS-1 (never wraps).
//  - credit_vld = (pending != 0).
//    credit_packet = {1'b1, ret_leaf_reg, ret_port_reg, rsvd=0, FREESPACE_UPDATE_SIZE[NUM_ADDR_BITS-1:0], PAYLOAD 0}.
//  - update_ret_en is applied next edge. A change while credit_vld is high is allowed and takes effect immediately.
//  - ap_start low: no new loads; an already-valid out word stays presented.
// CONFIGURATION
//  INPUT_PORT_ERR_CHK_EN defined: a write to an address whose bitmap bit is 1 is dropped.
//    It sets sticky output err_overwrite (1 bit, cleared only by reset).
//  Not defined: the write overwrites mem and bitmap stays 1. No err_overwrite port.
// TESTING
//  - Reset: assert reset mid-stream with 5 buffered words -> all outputs 0 and bitmap cleared at once.
//    After release, writing addr 0 delivers only the new word.
//  - In-order: 3 packets addr 0,1,2, payload 0xA,0xB,0xC, ack=1 -> user sees A,B,C on cycles N+2..N+4.
//  - Hole: write addr 1 then addr 0 two cycles later -> no vld until addr 0 is written, then words 0,1 in order.
//  - Port filter: packet with dst_port=PORT_ID+1 or vld=0 -> nothing buffered, vld stays 0.
//  - Credit: consume 64 words with credit_ack=0, then 64 more -> pending=2, credit_vld=1.
//    Addr field = 64; two credit_ack pulses -> credit_vld=0.
//  - Wrap/error: stream 130 words through addr 127->0 -> rd_ptr wraps, order kept.
//    With INPUT_PORT_ERR_CHK_EN, a second write to an unread addr 5 -> dropped, err_overwrite=1.

Source files
------------

// File: rtl/input_port_ydma_if.sv
// rtl/input_port_ydma_if.sv - network, user-stream and credit signals of the ydma input port
interface input_port_ydma_if #(
  parameter int PACKET_BITS  = 97,
  parameter int PAYLOAD_BITS = 64
);
  logic [PACKET_BITS-1:0]  internal_in;
  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
  logic                    vld_interface2user;
  logic                    ack_user2interface;
  logic [PACKET_BITS-1:0]  credit_packet;
  logic                    credit_vld;
  logic                    credit_ack;

  modport master (
    output internal_in, ack_user2interface, credit_ack,
    input  dout_leaf_interface2user, vld_interface2user, credit_packet, credit_vld
  );

  modport slave (
    input  internal_in, ack_user2interface, credit_ack,
    output dout_leaf_interface2user, vld_interface2user, credit_packet, credit_vld
  );
endinterface

// File: rtl/input_port_ydma.sv
// rtl/input_port_ydma.sv - BFT receive port: addressed reorder buffer, in-order user stream, credit return
// Optional macro INPUT_PORT_ERR_CHK_EN: drop writes to occupied entries and flag sticky err_overwrite.
module input_port_ydma #(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PAYLOAD_BITS          = 64,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int PORT_ID               = 2,
  parameter int CREDIT_CNT_BITS       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input_port_ydma_if.slave         bus,
  input  logic [NUM_LEAF_BITS-1:0] ret_leaf,
  input  logic [NUM_PORT_BITS-1:0] ret_port,
  input  logic                     update_ret_en,
  input  logic                     ap_start
`ifdef INPUT_PORT_ERR_CHK_EN
  ,
  output logic                     err_overwrite
`endif
);

  localparam int DEPTH     = 1 << NUM_ADDR_BITS;
  localparam int RSVD_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - NUM_ADDR_BITS - PAYLOAD_BITS;
  localparam int PORT_LSB  = PAYLOAD_BITS + NUM_ADDR_BITS + RSVD_BITS;
  localparam logic [NUM_ADDR_BITS-1:0]   CREDIT_WORDS = NUM_ADDR_BITS'(FREESPACE_UPDATE_SIZE);
  localparam logic [CREDIT_CNT_BITS-1:0] PENDING_MAX  = '1;

  logic [PAYLOAD_BITS-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]         bitmap;
  logic [NUM_ADDR_BITS-1:0] rd_ptr;
  logic [PAYLOAD_BITS-1:0]  dout;
  logic                     out_vld;
  logic [NUM_ADDR_BITS-1:0] consumed;
  logic [CREDIT_CNT_BITS-1:0] pending, pending_next;
  logic [NUM_LEAF_BITS-1:0] ret_leaf_reg;
  logic [NUM_PORT_BITS-1:0] ret_port_reg;

  logic                     in_vld;
  logic [NUM_PORT_BITS-1:0] in_port;
  logic [NUM_ADDR_BITS-1:0] in_addr;
  logic [PAYLOAD_BITS-1:0]  in_payload;
  logic                     accept, wr_en, load, handshake;
  logic                     credit_inc, credit_dec, credit_vld;

  assign in_vld     = bus.internal_in[PACKET_BITS-1];
  assign in_port    = bus.internal_in[PORT_LSB +: NUM_PORT_BITS];
  assign in_addr    = bus.internal_in[PAYLOAD_BITS +: NUM_ADDR_BITS];
  assign in_payload = bus.internal_in[PAYLOAD_BITS-1:0];

  // Leaf id and reserved bits are routing-only; this port does not need them.
  logic unused_in_bits;
  assign unused_in_bits = &{1'b0, bus.internal_in[PACKET_BITS-2 -: NUM_LEAF_BITS],
                            bus.internal_in[PAYLOAD_BITS+NUM_ADDR_BITS +: RSVD_BITS]};

  assign accept = in_vld && (in_port == NUM_PORT_BITS'(PORT_ID));
`ifdef INPUT_PORT_ERR_CHK_EN
  assign wr_en  = accept && !bitmap[in_addr];
`else
  assign wr_en  = accept;
`endif

  // The load reads the bitmap before this edge's write, so a same-cycle write waits a cycle.
  assign load      = bitmap[rd_ptr] && ap_start && (!out_vld || bus.ack_user2interface);
  assign handshake = out_vld && bus.ack_user2interface;

  always_ff @(posedge clk) begin
    if (wr_en) mem[in_addr] <= in_payload;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap  <= '0;
      rd_ptr  <= '0;
      dout    <= '0;
      out_vld <= 1'b0;
    end else begin
      if (load) begin
        bitmap[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
        dout           <= mem[rd_ptr];
      end
      if (wr_en) bitmap[in_addr] <= 1'b1;
      if (load)
        out_vld <= 1'b1;
      else if (bus.ack_user2interface)
        out_vld <= 1'b0;
    end
  end

  assign credit_inc = handshake && (consumed == CREDIT_WORDS - 1'b1);
  assign credit_dec = credit_vld && bus.credit_ack;
  assign credit_vld = (pending != '0);

  always_comb begin
    pending_next = pending;
    if (credit_inc && !credit_dec) begin
      if (pending != PENDING_MAX) pending_next = pending + 1'b1;
    end else if (!credit_inc && credit_dec) begin
      pending_next = pending - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      consumed     <= '0;
      pending      <= '0;
      ret_leaf_reg <= '0;
      ret_port_reg <= '0;
    end else begin
      if (credit_inc)
        consumed <= '0;
      else if (handshake)
        consumed <= consumed + 1'b1;
      pending <= pending_next;
      if (update_ret_en) begin
        ret_leaf_reg <= ret_leaf;
        ret_port_reg <= ret_port;
      end
    end
  end

`ifdef INPUT_PORT_ERR_CHK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_overwrite <= 1'b0;
    else if (accept && bitmap[in_addr])
      err_overwrite <= 1'b1;
  end
`endif

  assign bus.dout_leaf_interface2user = dout;
  assign bus.vld_interface2user       = out_vld;
  assign bus.credit_vld               = credit_vld;
  // Packet is zeroed while no credit is pending so every output reads 0 out of reset.
  assign bus.credit_packet = credit_vld ?
      {1'b1, ret_leaf_reg, ret_port_reg, {RSVD_BITS{1'b0}}, CREDIT_WORDS, {PAYLOAD_BITS{1'b0}}} :
      '0;

endmodule

// File: tb/tb_input_port_ydma.sv
// tb/tb_input_port_ydma.sv - self-checking bench for input_port_ydma (scoreboard plus vector table)
module tb_input_port_ydma;

  localparam int PB = 97;
  localparam int DB = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] ret_leaf;
  logic [3:0] ret_port;
  logic       update_ret_en;
  logic       ap_start;
`ifdef INPUT_PORT_ERR_CHK_EN
  logic       err_overwrite;
`endif

  always #5 clk = ~clk;

  input_port_ydma_if #(.PACKET_BITS(PB), .PAYLOAD_BITS(DB)) bus ();

  input_port_ydma dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .ret_leaf      (ret_leaf),
    .ret_port      (ret_port),
    .update_ret_en (update_ret_en),
`ifdef INPUT_PORT_ERR_CHK_EN
    .err_overwrite (err_overwrite),
`endif
    .ap_start      (ap_start)
  );

  int tests = 0;
  int fails = 0;
  int hs_count = 0;
  logic [DB-1:0] exp_q[$];
  logic [6:0] next_addr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [127:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h expected no word", name, act);
  endtask

  function automatic logic [PB-1:0] mk(input logic v, input logic [3:0] port,
                                       input logic [6:0] addr, input logic [DB-1:0] d);
    mk = {v, 6'd0, port, 15'd0, addr, d};
  endfunction

  function automatic logic [PB-1:0] credit_exp(input logic [5:0] leaf, input logic [3:0] port);
    credit_exp = {1'b1, leaf, port, 15'd0, 7'd64, 64'd0};
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  logic          hold_prev = 1'b0;
  logic [DB-1:0] prev_dout = '0;
  always @(negedge clk) begin
    if (reset) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_vld", 128'(bus.vld_interface2user), 128'd1);
        check("hold_data", 128'(bus.dout_leaf_interface2user), 128'(prev_dout));
      end
      if (bus.vld_interface2user && bus.ack_user2interface) begin
        if (exp_q.size() == 0)
          note_fail("unexpected_word", 128'(bus.dout_leaf_interface2user));
        else
          check("sb_data", 128'(bus.dout_leaf_interface2user), 128'(exp_q.pop_front()));
        hs_count <= hs_count + 1;
      end
      hold_prev <= bus.vld_interface2user && !bus.ack_user2interface;
      prev_dout <= bus.dout_leaf_interface2user;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [3:0] port, input logic [6:0] addr, input logic [DB-1:0] d);
    bus.internal_in = mk(v, port, addr, d);
    tick();
    bus.internal_in = '0;
  endtask

  task automatic stream(input int n);
    logic [DB-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      exp_q.push_back(d);
      send(1'b1, 4'd2, next_addr, d);
      next_addr = next_addr + 7'd1;
    end
    repeat (3) tick();
  endtask

  task automatic credit_pulse();
    bus.credit_ack = 1'b1;
    tick();
    bus.credit_ack = 1'b0;
  endtask

  task automatic set_ret(input logic [5:0] leaf, input logic [3:0] port);
    ret_leaf = leaf;
    ret_port = port;
    update_ret_en = 1'b1;
    tick();
    update_ret_en = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [3:0] port;
    logic       accept;
  } filt_vec_t;

  initial begin
    filt_vec_t vec[4];
    int base;
    int old_addr;
    logic [DB-1:0] d0, d1;

    vec[0] = '{1'b0, 4'd2, 1'b0};
    vec[1] = '{1'b1, 4'd3, 1'b0};
    vec[2] = '{1'b1, 4'd0, 1'b0};
    vec[3] = '{1'b1, 4'd2, 1'b1};

    reset = 1'b1;
    bus.internal_in = '0;
    bus.ack_user2interface = 1'b0;
    bus.credit_ack = 1'b0;
    ap_start = 1'b0;
    ret_leaf = '0;
    ret_port = '0;
    update_ret_en = 1'b0;
    repeat (2) tick();
    check("rst_vld", 128'(bus.vld_interface2user), 128'd0);
    check("rst_dout", 128'(bus.dout_leaf_interface2user), 128'd0);
    check("rst_cvld", 128'(bus.credit_vld), 128'd0);
    check("rst_cpkt", 128'(bus.credit_packet), 128'd0);
    reset = 1'b0;
    tick();
    set_ret(6'h2A, 4'd5);

    // In-order delivery with two-cycle latency.
    ap_start = 1'b1;
    bus.ack_user2interface = 1'b1;
    exp_q.push_back(64'hA); exp_q.push_back(64'hB); exp_q.push_back(64'hC);
    send(1'b1, 4'd2, 7'd0, 64'hA);
    check("lat_n1_vld", 128'(bus.vld_interface2user), 128'd0);
    send(1'b1, 4'd2, 7'd1, 64'hB);
    check("lat_n2_vld", 128'(bus.vld_interface2user), 128'd1);
    check("lat_n2_dout", 128'(bus.dout_leaf_interface2user), 128'hA);
    send(1'b1, 4'd2, 7'd2, 64'hC);
    check("lat_n3_dout", 128'(bus.dout_leaf_interface2user), 128'hB);
    tick();
    check("lat_n4_dout", 128'(bus.dout_leaf_interface2user), 128'hC);
    tick();
    check("lat_n5_vld", 128'(bus.vld_interface2user), 128'd0);
    next_addr = 7'd3;

    // Port / valid filter vectors.
    for (int i = 0; i < 4; i++) begin
      base = hs_count;
      d0 = 64'h1000 + 64'(i);
      if (vec[i].accept) exp_q.push_back(d0);
      send(vec[i].v, vec[i].port, next_addr, d0);
      if (vec[i].accept) next_addr = next_addr + 7'd1;
      repeat (3) tick();
      check("filter_hs", 128'(hs_count - base), 128'(vec[i].accept));
      check("filter_vld", 128'(bus.vld_interface2user), 128'd0);
    end

    // Hole: higher address first, the missing one two cycles later.
    base = hs_count;
    d0 = 64'h5EED_0000; d1 = 64'h5EED_0001;
    exp_q.push_back(d0); exp_q.push_back(d1);
    send(1'b1, 4'd2, next_addr + 7'd1, d1);
    tick();
    check("hole_wait", 128'(bus.vld_interface2user), 128'd0);
    send(1'b1, 4'd2, next_addr, d0);
    check("hole_fill_n1", 128'(bus.vld_interface2user), 128'd0);
    tick();
    check("hole_first", 128'(bus.dout_leaf_interface2user), 128'(d0));
    repeat (3) tick();
    check("hole_hs", 128'(hs_count - base), 128'd2);
    next_addr = next_addr + 7'd2;

    // ap_start gating and presentation hold.
    ap_start = 1'b0;
    d0 = 64'hA5A5;
    exp_q.push_back(d0);
    send(1'b1, 4'd2, next_addr, d0);
    repeat (3) tick();
    check("apstart_off", 128'(bus.vld_interface2user), 128'd0);
    bus.ack_user2interface = 1'b0;
    ap_start = 1'b1;
    tick();
    check("apstart_on", 128'(bus.dout_leaf_interface2user), 128'(d0));
    ap_start = 1'b0;
    repeat (2) tick();
    check("apstart_hold", 128'(bus.vld_interface2user), 128'd1);
    bus.ack_user2interface = 1'b1;
    tick();
    check("apstart_drain", 128'(bus.vld_interface2user), 128'd0);
    ap_start = 1'b1;
    next_addr = next_addr + 7'd1;

    // Random backpressure.
    base = hs_count;
    for (int i = 0; i < 6; i++) begin
      d0 = {$urandom, $urandom};
      exp_q.push_back(d0);
      bus.ack_user2interface = 1'($urandom_range(0, 1));
      send(1'b1, 4'd2, next_addr, d0);
      next_addr = next_addr + 7'd1;
    end
    for (int i = 0; i < 40 && (hs_count - base) < 6; i++) begin
      bus.ack_user2interface = 1'($urandom_range(0, 1));
      tick();
    end
    bus.ack_user2interface = 1'b1;
    repeat (2) tick();
    check("bp_drain", 128'(hs_count - base), 128'd6);

    // Double write to an unread address.
    base = hs_count;
    ap_start = 1'b0;
    d0 = 64'hF1F1; d1 = 64'hF2F2;
    send(1'b1, 4'd2, next_addr, d0);
`ifdef INPUT_PORT_ERR_CHK_EN
    check("err_clear", 128'(err_overwrite), 128'd0);
`endif
    send(1'b1, 4'd2, next_addr, d1);
`ifdef INPUT_PORT_ERR_CHK_EN
    exp_q.push_back(d0);
    check("err_set", 128'(err_overwrite), 128'd1);
`else
    exp_q.push_back(d1);
`endif
    ap_start = 1'b1;
    repeat (4) tick();
    check("dup_hs", 128'(hs_count - base), 128'd1);
    next_addr = next_addr + 7'd1;

    // Reset mid-stream with buffered words and one presented.
    bus.ack_user2interface = 1'b0;
    old_addr = int'(next_addr);
    for (int i = 0; i < 5; i++) send(1'b1, 4'd2, next_addr + 7'(i), 64'hDEAD_0000 + 64'(i));
    tick();
    check("pre_rst_vld", 128'(bus.vld_interface2user), 128'd1);
    reset = 1'b1;
    #1;
    check("rst_async_vld", 128'(bus.vld_interface2user), 128'd0);
    check("rst_async_dout", 128'(bus.dout_leaf_interface2user), 128'd0);
`ifdef INPUT_PORT_ERR_CHK_EN
    check("rst_err", 128'(err_overwrite), 128'd0);
`endif
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    set_ret(6'h2A, 4'd5);
    base = hs_count;
    next_addr = 7'd0;
    bus.ack_user2interface = 1'b1;
    stream(old_addr);
    repeat (5) tick();
    check("rst_clear_hs", 128'(hs_count - base), 128'(old_addr));
    check("rst_clear_vld", 128'(bus.vld_interface2user), 128'd0);

    // Credits: boundary at 64 consumed words, then a second batch.
    stream(63 - old_addr);
    check("credit_63", 128'(bus.credit_vld), 128'd0);
    stream(1);
    check("credit_64", 128'(bus.credit_vld), 128'd1);
    check("credit_pkt", 128'(bus.credit_packet), 128'(credit_exp(6'h2A, 4'd5)));
    stream(64);
    credit_pulse();
    check("credit_ack1", 128'(bus.credit_vld), 128'd1);
    set_ret(6'h15, 4'd9);
    check("credit_pkt_new_ret", 128'(bus.credit_packet), 128'(credit_exp(6'h15, 4'd9)));
    credit_pulse();
    check("credit_ack2", 128'(bus.credit_vld), 128'd0);
    check("credit_pkt_idle", 128'(bus.credit_packet), 128'd0);

    // Sixteen credits earned with no acks: counter must saturate at 15.
    for (int i = 0; i < 16; i++) stream(64);
    for (int i = 0; i < 14; i++) credit_pulse();
    check("sat_14_acks", 128'(bus.credit_vld), 128'd1);
    credit_pulse();
    check("sat_15_acks", 128'(bus.credit_vld), 128'd0);

    check("sb_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
